// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the RV32I fetch stage:
//   NOP_INST       canonical bubble encoding (addi x0,x0,0)
//   fetch_state_t  fetch FSM states
//   if_id_t        contents of the IF/ID pipeline register
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with priority rst > flush > stall > load.
// When nothing is loaded, a bubble (NOP, valid=0) is inserted and the PC
// field keeps its previous value.
// Ports:
//   clk      rising-edge clock
//   i_rst    synchronous active-high reset
//   i_flush  replace contents with a bubble (pc kept)
//   i_stall  hold all fields
//   i_load   capture i_d this cycle
//   i_d      incoming {pc, inst, valid}
//   o_q      registered IF/ID contents
// -----------------------------------------------------------------------------
module if_id_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_stall,
    input  logic                   i_load,
    input  fetch_unit_pkg::if_id_t i_d,
    output fetch_unit_pkg::if_id_t o_q
);
    import fetch_unit_pkg::*;

    if_id_t r_q;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_q.pc    <= 32'h0000_0000;
            r_q.inst  <= NOP_INST;
            r_q.valid <= 1'b0;
        end else if (i_flush) begin
            r_q.inst  <= NOP_INST;
            r_q.valid <= 1'b0;
        end else if (i_stall) begin
            r_q <= r_q;
        end else if (i_load) begin
            r_q <= i_d;
        end else begin
            r_q.inst  <= NOP_INST;
            r_q.valid <= 1'b0;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// IF stage and IF/ID register of the five-stage RV32I core. Owns the PC and
// fetches over a req/gnt/rvalid handshake with at most one request in flight.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   REQ   | no request outstanding; presenting pc_if
//   WAIT  | one granted request outstanding (kill marks it wrong-path)
//   HOLD  | fetched instruction parked in the skid register
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   stall_if, stall_id, flush_id   hazard controls
//   br_taken, br_target            redirect from EX
//   imem_req/addr/gnt              request channel
//   imem_rvalid/rdata              response channel
//   pc_id, inst_id, valid_id       IF/ID register outputs to decode
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush_id,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_id,
    output logic [31:0] inst_id,
    output logic        valid_id
);
    import fetch_unit_pkg::*;

    fetch_state_t r_state;
    logic [31:0]  r_pc_if;
    logic         r_kill;
    // In HOLD the parked instruction's PC is r_pc_if itself (pc_if only
    // advances on delivery), so the skid only needs the instruction word.
    logic [31:0]  r_skid_inst;

    logic         w_accept;
    logic         w_rsp_ok;
    logic         w_deliver;
    logic [31:0]  w_pc_inc;
    if_id_t       w_if_id_d;
    if_id_t       w_if_id_q;
    logic         w_unused;

    assign w_accept  = !stall_if && !stall_id && !br_taken;
    assign w_rsp_ok  = (r_state == WAIT) && imem_rvalid && !r_kill;
    assign w_deliver = (w_rsp_ok || (r_state == HOLD)) && w_accept;
    assign w_pc_inc  = r_pc_if + 32'd4;

    // Redirect targets are word aligned by dropping the low bits.
    assign w_unused = ^br_target[1:0];

    // Request channel. Back-to-back fetch: when a response is delivered the
    // next address goes out in the same cycle, keeping zero-wait memory at
    // one instruction per cycle. If that request is not granted, REQ will
    // present the same (already advanced) pc_if, so the address is stable.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_pc_if;
        if (!rst && !br_taken) begin
            case (r_state)
                REQ: begin
                    imem_req  = 1'b1;
                    imem_addr = r_pc_if;
                end
                WAIT: begin
                    if (w_rsp_ok && w_accept) begin
                        imem_req  = 1'b1;
                        imem_addr = w_pc_inc;
                    end
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= REQ;
            r_pc_if     <= {RESET_PC[31:2], 2'b00};
            r_kill      <= 1'b0;
            r_skid_inst <= NOP_INST;
        end else if (br_taken) begin
            r_pc_if <= {br_target[31:2], 2'b00};
            // An in-flight request whose response has not yet arrived must
            // still be drained; mark it so its data is dropped.
            if ((r_state == WAIT) && !imem_rvalid) begin
                r_state <= WAIT;
                r_kill  <= 1'b1;
            end else begin
                r_state <= REQ;
                r_kill  <= 1'b0;
            end
        end else begin
            case (r_state)
                REQ: begin
                    if (imem_gnt) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= REQ;
                        end else if (w_accept) begin
                            r_pc_if <= w_pc_inc;
                            r_state <= imem_gnt ? WAIT : REQ;
                        end else begin
                            r_skid_inst <= imem_rdata;
                            r_state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        r_pc_if <= w_pc_inc;
                        r_state <= REQ;
                    end
                end
                default: begin
                    r_state <= REQ;
                end
            endcase
        end
    end

    always_comb begin
        w_if_id_d.pc    = r_pc_if;
        w_if_id_d.inst  = (r_state == HOLD) ? r_skid_inst : imem_rdata;
        w_if_id_d.valid = 1'b1;
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk     (clk),
        .i_rst   (rst),
        .i_flush (flush_id),
        .i_stall (stall_id),
        .i_load  (w_deliver),
        .i_d     (w_if_id_d),
        .o_q     (w_if_id_q)
    );

    assign pc_id    = w_if_id_q.pc;
    assign inst_id  = w_if_id_q.inst;
    assign valid_id = w_if_id_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A small memory responder grants whenever
// gnt_en is set and returns the request address as data after 'lat' cycles.
// Inputs change and outputs are checked just after the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        stall_id;
    logic        flush_id;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_id;
    logic [31:0] inst_id;
    logic        valid_id;

    // responder
    logic        gnt_en;
    int          lat;
    logic        tb_rst;
    logic        pend;
    logic [31:0] pend_addr;
    int          cnt;

    int total;
    int bad;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .flush_id    (flush_id),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_id       (pc_id),
        .inst_id     (inst_id),
        .valid_id    (valid_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_gnt    = gnt_en & imem_req;
    assign imem_rvalid = pend && (cnt == 0);
    assign imem_rdata  = pend_addr;

    always @(posedge clk) begin
        if (tb_rst) begin
            pend      <= 1'b0;
            pend_addr <= 32'h0;
            cnt       <= 0;
        end else begin
            if (imem_rvalid)
                pend <= 1'b0;
            else if (pend && cnt > 0)
                cnt <= cnt - 1;
            if (imem_req && imem_gnt) begin
                pend      <= 1'b1;
                pend_addr <= imem_addr;
                cnt       <= lat - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic vld);
        chk({tag, "_valid"}, {31'd0, valid_id}, {31'd0, vld});
        chk({tag, "_inst"}, inst_id, inst);
        chk({tag, "_pc"}, pc_id, pc);
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) chk({tag, "_addr"}, imem_addr, addr);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; flush_id = 1'b0;
        br_taken = 1'b0; br_target = 32'h0;
        gnt_en = 1'b1; lat = 1; tb_rst = 1'b1;

        repeat (2) @(negedge clk);
        tb_rst = 1'b0;
        #1;
        chk_id("reset", 32'h0, NOP, 1'b0);
        chk_req("reset", 1'b0, 32'h0);

        // C0: first request from RESET_PC
        @(negedge clk); rst = 1'b0; #1;
        chk_req("c0", 1'b1, 32'h0);
        // C1: response for 0, back-to-back request for 4, ID still empty
        @(negedge clk); #1;
        chk({"c1_valid"}, {31'd0, valid_id}, 32'd0);
        chk_req("c1", 1'b1, 32'h4);
        // C2: first valid instruction
        @(negedge clk); #1;
        chk_id("c2", 32'h0, 32'h0, 1'b1);
        chk_req("c2", 1'b1, 32'h8);

        // C3..C5: full stall on the cycle 0x8 returns -> HOLD, no request
        @(negedge clk); stall_id = 1'b1; stall_if = 1'b1; #1;
        chk_id("c3", 32'h4, 32'h4, 1'b1);
        chk_req("c3", 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk_id("stall_hold", 32'h4, 32'h4, 1'b1);
            chk_req("stall_hold", 1'b0, 32'h0);
        end
        // C6: release, skid delivered, no request from HOLD
        @(negedge clk); stall_id = 1'b0; stall_if = 1'b0; #1;
        chk_req("c6", 1'b0, 32'h0);
        // C7: skid instruction reaches ID
        @(negedge clk); #1;
        chk_id("c7", 32'h8, 32'h8, 1'b1);
        chk_req("c7", 1'b1, 32'hC);
        // C8: bubble while 0xC is in flight
        @(negedge clk); #1;
        chk({"c8_valid"}, {31'd0, valid_id}, 32'd0);
        // C9: 0xC arrives in ID; next grant uses latency 2
        @(negedge clk); lat = 2; #1;
        chk_id("c9", 32'hC, 32'hC, 1'b1);
        chk_req("c9", 1'b1, 32'h14);

        // C10: redirect while waiting on 0x14
        @(negedge clk); br_taken = 1'b1; br_target = 32'h100; #1;
        chk_id("c10", 32'h10, 32'h10, 1'b1);
        chk_req("c10", 1'b0, 32'h0);
        // C11: wrong-path 0x14 returns and is dropped
        @(negedge clk); br_taken = 1'b0; #1;
        chk({"c11_valid"}, {31'd0, valid_id}, 32'd0);
        chk_req("c11", 1'b0, 32'h0);
        // C12: fetch from target
        @(negedge clk); #1;
        chk({"c12_valid"}, {31'd0, valid_id}, 32'd0);
        chk_req("c12", 1'b1, 32'h100);
        @(negedge clk); #1;
        chk({"c13_valid"}, {31'd0, valid_id}, 32'd0);
        chk_req("c13", 1'b0, 32'h0);
        @(negedge clk); lat = 1; #1;
        chk({"c14_valid"}, {31'd0, valid_id}, 32'd0);
        chk_req("c14", 1'b1, 32'h104);
        // C15: target instruction in ID; flush and stall together
        @(negedge clk); flush_id = 1'b1; stall_id = 1'b1; #1;
        chk_id("c15", 32'h100, 32'h100, 1'b1);
        // C16: flush wins over stall
        @(negedge clk); flush_id = 1'b0; stall_id = 1'b0; #1;
        chk_id("flush_vs_stall", 32'h100, NOP, 1'b0);
        chk_req("c16", 1'b0, 32'h0);

        // C17: misaligned redirect to 0x23, grant withheld
        @(negedge clk); br_taken = 1'b1; br_target = 32'h23; gnt_en = 1'b0; #1;
        chk_id("c17", 32'h104, 32'h104, 1'b1);
        chk_req("c17", 1'b0, 32'h0);
        @(negedge clk); br_taken = 1'b0; #1;
        chk_req("nognt0", 1'b1, 32'h20);
        chk({"nognt0_valid"}, {31'd0, valid_id}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); #1;
            chk_req("nognt", 1'b1, 32'h20);
            chk({"nognt_valid"}, {31'd0, valid_id}, 32'd0);
        end
        // C22: grant resumes
        @(negedge clk); gnt_en = 1'b1; #1;
        chk_req("c22", 1'b1, 32'h20);
        @(negedge clk); lat = 3; #1;
        chk_req("c23", 1'b1, 32'h24);
        chk({"c23_valid"}, {31'd0, valid_id}, 32'd0);

        // C24: reset while 0x24 is outstanding
        @(negedge clk); rst = 1'b1; #1;
        chk_id("c24", 32'h20, 32'h20, 1'b1);
        chk_req("c24_rst", 1'b0, 32'h0);
        // C25: reset values restored, fetching RESET_PC without grant
        @(negedge clk); rst = 1'b0; gnt_en = 1'b0; lat = 1; #1;
        chk_id("post_rst", 32'h0, NOP, 1'b0);
        chk_req("post_rst", 1'b1, 32'h0);
        // C26: stale response arrives while in REQ; must be ignored
        @(negedge clk); gnt_en = 1'b1; #1;
        chk_req("stale", 1'b1, 32'h0);
        chk({"stale_valid"}, {31'd0, valid_id}, 32'd0);
        @(negedge clk); #1;
        chk({"c27_valid"}, {31'd0, valid_id}, 32'd0);
        chk_req("c27", 1'b1, 32'h4);

        // C28: redirect to the top word of the address space
        @(negedge clk); br_taken = 1'b1; br_target = 32'hFFFF_FFFC; #1;
        chk_id("c28", 32'h0, 32'h0, 1'b1);
        chk_req("c28", 1'b0, 32'h0);
        @(negedge clk); br_taken = 1'b0; #1;
        chk_req("c29", 1'b1, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk_req("wrap_addr", 1'b1, 32'h0);
        @(negedge clk); #1;
        chk_id("top_word", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
        @(negedge clk); #1;
        chk_id("wrapped", 32'h0, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage plus IF/ID pipeline register for the five-stage RV32I core.
- Owns the PC and fetches over a req/gnt/rvalid instruction-memory handshake, with at most one request outstanding.
- Consumes the hazard controls (stall_if, stall_id, flush_id, br_taken) and presents pc_id, inst_id and valid_id to decode.
- Inserts bubbles (NOP, valid_id=0) whenever memory latency leaves decode without an instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
NOP_INST, 32'h0000_0013, encoding (addi x0,x0,0) driven on inst_id for bubbles/flushes

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
stall_if  in  1  hazard unit: hold PC / do not advance fetch
stall_id  in  1  hazard unit: hold IF/ID register
flush_id  in  1  hazard unit: load bubble into IF/ID
br_taken  in  1  redirect request from EX
br_target  in  32  redirect PC
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid (exactly one per granted request, ≥1 cycle after gnt)
imem_rdata  in  32  instruction data
pc_id  out  32  PC of instruction in ID
inst_id  out  32  instruction in ID
valid_id  out  1  inst_id is a real instruction

Behaviour:
- States: REQ (no request outstanding), WAIT (one granted request outstanding), HOLD (one fetched instruction buffered in skid register).
- Reset (rst=1 at edge): state=REQ, pc_if=RESET_PC, kill=0, pc_id=0, inst_id=NOP_INST, valid_id=0. imem_req=0 while rst=1.
- accept = !stall_if & !stall_id & !br_taken.
- REQ: imem_req=!br_taken, imem_addr=pc_if. gnt -> WAIT. No gnt -> stay REQ.
- WAIT:
  - rvalid & !kill & accept: IF/ID <= {pc_if, rdata, valid=1}; pc_if += 4.
    - Also issue the next request in the same cycle: imem_req=1, imem_addr=pc_if+4.
    - gnt -> stay WAIT; no gnt -> REQ.
  - rvalid & !kill & !accept & !br_taken: capture {pc_if, rdata} into skid -> HOLD.
  - No rvalid: stay WAIT, imem_req=0.
- HOLD:
  - imem_req=0.
  - When accept: IF/ID <= skid (valid=1); pc_if += 4 -> REQ.
- Redirect (br_taken=1), highest priority after rst:
  - pc_if <= br_target; imem_req=0 that cycle.
  - REQ -> REQ.
  - HOLD -> REQ (skid dropped).
  - WAIT with rvalid -> REQ, data discarded.
  - WAIT without rvalid -> WAIT with kill=1.
- kill: in WAIT, rvalid with kill=1 is discarded, kill<=0 -> REQ. Wrong-path data never reaches ID.
- IF/ID register priority: rst > flush_id > stall_id > load.
  - flush_id: inst_id=NOP_INST, valid_id=0, pc_id unchanged.
  - stall_id: all three held.
  - Otherwise load fetched/skid instruction if delivered this cycle, else bubble (NOP, valid 0).
- Zero-wait memory (gnt same cycle, rvalid next cycle): steady-state throughput one instruction per cycle, first valid_id two cycles after rst deasserts.
- stall_if with stall_id=0 (not produced by current hazard unit): treated as accept=0. The instruction is held in skid; ID receives bubbles.
- pc arithmetic mod 2^32, wraps 0xFFFF_FFFC -> 0. br_target[1:0] ignored (forced 0 on imem_addr).
- imem_addr stable while imem_req=1 and gnt=0.

Decomposition:
- Shared rv_pkg: NOP_INST constant, fetch_state_t enum {REQ, WAIT, HOLD}, if_id_t struct {pc, inst, valid}.
- One natural sub-module: if_id_reg (flush/stall/load priority register on if_id_t).
- FSM, PC and skid live in fetch_unit.

Test Plan:
- Reset, then rst=0 with zero-wait memory returning addr as data -> imem_addr 0,4,8,…; valid_id=1 from cycle 2, inst_id=0,4,8 one per cycle.
- stall_id=stall_if=1 for 3 cycles on the cycle rvalid returns 0x8 -> HOLD entered, no new req, IF/ID held. After release, inst_id=0x8 then 0xC; no duplicate or lost instruction.
- br_taken=1, br_target=0x100 while in WAIT (rvalid 2 cycles later) -> kill set, returning data discarded, next imem_addr=0x100, valid_id=0 until 0x100 arrives.
- flush_id=1 and stall_id=1 same cycle -> inst_id=NOP_INST, valid_id=0 (flush wins).
- gnt withheld 4 cycles at pc=0x20 -> imem_req=1 and imem_addr=0x20 stable; ID sees bubbles; resumes on gnt.
- rst asserted in WAIT with response pending -> all outputs return to reset values next cycle; late rvalid ignored (state REQ, kill=0); first fetch from RESET_PC.
